// File: rtl/gate_share_arbiter.sv
// gate_share_arbiter: round-robin sharing of one registered two-input gate cell
// among NUM_REQ requesters. One operation in flight at a time; the winner's
// operands are latched at arbitration, the gate gets a one-cycle en_in pulse,
// and the result (or a timeout error) is returned to the winner.
//
// state | meaning
// IDLE  | waiting for any req; arbitration and operand latch happen here
// ISSUE | gnt and gate_en_in pulse for the winner
// WAIT  | waiting for gate_en_out, bounded by TIMEOUT
// RESP  | rsp_valid pulse to the winner, round-robin pointer advances
module gate_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] op_a,
  input  logic [NUM_REQ-1:0] op_b,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic               rsp_data,
  output logic               rsp_err,
  output logic               busy,
  output logic               gate_en_in,
  output logic               gate_in1,
  output logic               gate_in2,
  input  logic               gate_out,
  input  logic               gate_en_out
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [CNT_W-1:0]   tmo_cnt;

  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   cand_idx;
  int                 cand;

  // Round-robin pick: first set req bit scanning upward from rr_ptr with wrap.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand     = (int'(rr_ptr) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!arb_found && req[cand_idx]) begin
        arb_found = 1'b1;
        arb_idx   = cand_idx;
      end
    end
  end

  // Sequencer: all handshake and gate-drive outputs are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      win_idx    <= '0;
      tmo_cnt    <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= 1'b0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      gate_en_in <= 1'b0;
      gate_in1   <= 1'b0;
      gate_in2   <= 1'b0;
    end else begin
      gnt        <= '0;
      rsp_valid  <= '0;
      gate_en_in <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_found) begin
            win_idx    <= arb_idx;
            gate_in1   <= op_a[arb_idx];
            gate_in2   <= op_b[arb_idx];
            gnt        <= NUM_REQ'(1) << arb_idx;
            gate_en_in <= 1'b1;
            busy       <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          // en_out wins over the timeout check; TIMEOUT-1 WAIT cycles in total
          if (gate_en_out) begin
            rsp_data  <= gate_out;
            rsp_err   <= 1'b0;
            rsp_valid <= NUM_REQ'(1) << win_idx;
            state     <= S_RESP;
          end else if (tmo_cnt == CNT_W'(TIMEOUT - 2)) begin
            rsp_err   <= 1'b1;
            rsp_valid <= NUM_REQ'(1) << win_idx;
            state     <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: begin
          rr_ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
